// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor engine.
// Optional feature macro: SERIAL_SUB_SAT_EN (unsigned floor saturation).
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int calc_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int cnt_width(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_sub_engine_full_sub_cell.sv
// One-bit full subtractor cell: d = a - b - bin, bo = borrow out.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_engine.sv
// Multi-cycle subtractor retiring BITS_PER_CYCLE bits per cycle, LSB first.
// Define SERIAL_SUB_SAT_EN to floor the result at zero on borrow out.
module serial_sub_engine
    import serial_sub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = cnt_width(STEPS);

    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("serial_sub_engine: BITS_PER_CYCLE must divide WIDTH");
    end

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic                      brw;
    logic [CNT_W-1:0]          cnt;
    logic [BITS_PER_CYCLE:0]   chain;
    logic [BITS_PER_CYCLE-1:0] cell_d;
    logic [WIDTH-1:0]          shifted;
    logic [WIDTH-1:0]          diff_nxt;
    logic                      last;

    assign chain[0] = brw;
    assign last     = (cnt == CNT_W'(STEPS - 1));

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        full_sub_cell u_cell (
            .a   (a_sh[i]),
            .b   (b_sh[i]),
            .bin (chain[i]),
            .d   (cell_d[i]),
            .bo  (chain[i+1])
        );
    end

    // New result bits enter from the MSB side so the LSB slice lands at bit 0 last.
    if (STEPS == 1) begin : g_one
        assign shifted = cell_d;
    end else begin : g_many
        assign shifted = {cell_d, diff[WIDTH-1:BITS_PER_CYCLE]};
    end

    always_comb begin
        diff_nxt = shifted;
`ifdef SERIAL_SUB_SAT_EN
        if (last && chain[BITS_PER_CYCLE]) begin
            diff_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            a_sh <= a_sh >> BITS_PER_CYCLE;
            b_sh <= b_sh >> BITS_PER_CYCLE;
            brw  <= chain[BITS_PER_CYCLE];
            cnt  <= cnt + CNT_W'(1);
            diff <= diff_nxt;
            if (last) begin
                bout <= chain[BITS_PER_CYCLE];
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_engine.sv
// Bench for serial_sub_engine: three configurations against an arithmetic model.
module tb_serial_sub_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] iv = '0;
    logic [2:0] ordy = '0;
    logic [2:0] bi = '0;
    logic [7:0] av [3];
    logic [7:0] bv [3];

    wire  [2:0] ir;
    wire  [2:0] ov;
    wire  [2:0] bz;
    wire  [2:0] bo;
    wire  [7:0] d0;
    wire  [7:0] d1;
    wire  [0:0] d2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub_engine #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0]), .b(bv[0]), .bin(bi[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .diff(d0), .bout(bo[0]), .busy(bz[0])
    );

    serial_sub_engine #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .bin(bi[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .diff(d1), .bout(bo[1]), .busy(bz[1])
    );

    serial_sub_engine #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][0:0]), .b(bv[2][0:0]), .bin(bi[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .diff(d2), .bout(bo[2]), .busy(bz[2])
    );

    function automatic logic [7:0] dsel(input int k);
        case (k)
            0:       return d0;
            1:       return d1;
            default: return {7'b0, d2};
        endcase
    endfunction

    function automatic int steps_of(input int k);
        case (k)
            0:       return 8;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int mask_of(input int k);
        return (k == 2) ? 1 : 255;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, optional zero floor on borrow.
    task automatic model(input int k, input int x, input int y, input int c,
                         output int ed, output int eb);
        int m;
        int full;
        m    = mask_of(k);
        full = (x & m) - (y & m) - c;
        eb   = (full < 0) ? 1 : 0;
        ed   = full & m;
`ifdef SERIAL_SUB_SAT_EN
        if (eb == 1) ed = 0;
`endif
    endtask

    task automatic issue(input int k, input logic [7:0] x, input logic [7:0] y,
                         input logic c);
        iv[k] = 1'b1;
        av[k] = x;
        bv[k] = y;
        bi[k] = c;
        chk("in_ready_idle", int'(ir[k]), 1);
        @(posedge clk); #1;
        iv[k] = 1'b0;
        av[k] = 8'($urandom);
        bv[k] = 8'($urandom);
        bi[k] = 1'($urandom);
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (ov[k] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, steps_of(k));
    endtask

    task automatic check_result(input int k, input int x, input int y, input int c);
        int ed;
        int eb;
        model(k, x, y, c, ed, eb);
        chk("diff", int'(dsel(k)), ed);
        chk("bout", int'(bo[k]), eb);
    endtask

    task automatic retire(input int k);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk("ov_after_hs", int'(ov[k]), 0);
        chk("ir_after_hs", int'(ir[k]), 1);
    endtask

    task automatic op(input int k, input logic [7:0] x, input logic [7:0] y,
                      input logic c);
        issue(k, x, y, c);
        wait_done(k);
        check_result(k, int'(x), int'(y), int'(c));
        retire(k);
    endtask

    initial begin
        logic [7:0] hd;
        logic       hb;
        for (int k = 0; k < 3; k++) begin
            av[k] = '0;
            bv[k] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", int'(ir[k]), 1);
            chk("rst_out_valid", int'(ov[k]), 0);
            chk("rst_busy", int'(bz[k]), 0);
            chk("rst_diff", int'(dsel(k)), 0);
            chk("rst_bout", int'(bo[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(0, 8'h5A, 8'h3C, 1'b0);
        op(0, 8'h00, 8'h01, 1'b0);
        op(0, 8'hFF, 8'h00, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op(2, {7'b0, v[2]}, {7'b0, v[1]}, v[0]);
        end

        op(1, 8'hFF, 8'hFF, 1'b1);
        op(1, 8'h10, 8'h01, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            op(1, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 60; i++) begin
            op(0, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Backpressure: result must hold and new operands stay out while DONE.
        issue(0, 8'h13, 8'hA7, 1'b1);
        wait_done(0);
        check_result(0, 'h13, 'hA7, 1);
        hd = d0;
        hb = bo[0];
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            av[0] = 8'($urandom);
            bv[0] = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", int'(ov[0]), 1);
            chk("bp_in_ready", int'(ir[0]), 0);
            chk("bp_diff", int'(d0), int'(hd));
            chk("bp_bout", int'(bo[0]), int'(hb));
        end
        iv[0] = 1'b0;
        retire(0);
        chk("bp_busy_idle", int'(bz[0]), 0);

        // Reset during RUN aborts the operation.
        issue(0, 8'hC3, 8'h21, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", int'(bz[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", int'(ov[0]), 0);
        chk("ar_diff", int'(d0), 0);
        chk("ar_busy", int'(bz[0]), 0);
        chk("ar_bout", int'(bo[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_in_ready", int'(ir[0]), 1);
        op(0, 8'h80, 8'h7F, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
